// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - FSM state encodings (ST_FETCH .. ST_JAL)
//   - opcode constants for the supported instruction set
//   - ALUOp codes and datapath mux-select constants
//   - op_supported(): opcode legality check used by the decoder
//   - op_zero_ext(): opcodes whose immediate is zero-extended
// Optional feature macro: MULTICYCLE_CUSTOM_OPS_EN (jal, andi, ori).
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IMMEX  = 4'd10,
    ST_IMMWB  = 4'd11,
    ST_JAL    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  // ALUOp codes fit in 3 bits; the decoder widens them to ALUOP_W.
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
`ifdef MULTICYCLE_CUSTOM_OPS_EN
    ok = ok || (op == OP_JAL) || (op == OP_ANDI) || (op == OP_ORI);
`endif
    return ok;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_zero_ext(input logic [5:0] op);
`ifdef MULTICYCLE_CUSTOM_OPS_EN
    return (op == OP_ANDI) || (op == OP_ORI);
`else
    return (op == 6'h3F) && 1'b0;
`endif
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath.
//   op, mem_ready          : datapath -> controller (IR opcode, memory handshake)
//   PCWrite .. ExtMode     : controller -> datapath enables and mux selects
//   illegal_op, state      : controller status / debug
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int ALUOP_W  = 4,
  parameter int REGDST_W = 2,
  parameter int STATE_W  = 4
);
  logic [5:0]          op;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemtoReg;
  logic [REGDST_W-1:0] RegDst;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [1:0]          PCSource;
  logic                PCToReg;
  logic                ExtMode;
  logic                illegal_op;
  logic [STATE_W-1:0]  state;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, PCToReg,
           ExtMode, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, PCToReg,
           ExtMode, illegal_op, state
  );
endinterface

// File: rtl/multicycle_out_decode.sv
// Combinational control-word decoder: state (+ op, mem_ready) -> datapath
// enables and mux selects. Mostly Moore; the only input-dependent terms are
// the FETCH IRWrite/PCWrite gating on mem_ready and illegal_op in DECODE
// (plus the ALUOp/ExtMode choice in the immediate path, from the held IR).
// Optional feature macro: MULTICYCLE_CUSTOM_OPS_EN (JAL state, andi/ori).
module multicycle_out_decode
  import multicycle_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int REGDST_W = 2
) (
  input  state_e              state,
  input  logic [5:0]          op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic [REGDST_W-1:0] reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                pc_to_reg,
  output logic                ext_mode,
  output logic                illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = REGDST_W'(REGDST_RT);
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALU_ADD);
    pc_source     = PCSRC_ALU;
    pc_to_reg     = 1'b0;
    ext_mode      = 1'b1;
    illegal_op    = 1'b0;

    case (state)
      ST_FETCH: begin
        // PC+4 and IR load only commit once the instruction word arrives.
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      ST_DECODE: begin
        // Branch target precompute: PC + (imm << 2).
        alu_src_b  = SRCB_IMMSH2;
        illegal_op = ~op_supported(op);
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_RTYPE);
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_W'(REGDST_RD);
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ST_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_mode  = ~op_zero_ext(op);
`ifdef MULTICYCLE_CUSTOM_OPS_EN
        if (op == OP_ANDI)     alu_op = ALUOP_W'(ALU_AND);
        else if (op == OP_ORI) alu_op = ALUOP_W'(ALU_OR);
`endif
      end
      ST_IMMWB: begin
        reg_write = 1'b1;
        ext_mode  = ~op_zero_ext(op);
      end
`ifdef MULTICYCLE_CUSTOM_OPS_EN
      ST_JAL: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        reg_write = 1'b1;
        reg_dst   = REGDST_W'(REGDST_RA);
        pc_to_reg = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: one FSM sequencing FETCH, DECODE, execute,
// memory and writeback, stalling on mem_ready and flagging unsupported
// opcodes. The state register and next-state logic live here; the control
// word comes from multicycle_out_decode.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH and zeroes every output
//   bus   : multicycle_control_if.master (op/mem_ready in, controls out)
// Parameters: ALUOP_W (>=3), REGDST_W (>=2), STATE_W (>=4).
// Optional feature macro: MULTICYCLE_CUSTOM_OPS_EN (jal, andi, ori).
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int REGDST_W = 2,
  parameter int STATE_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_e state_q, state_d;

  logic                pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic                ir_write, mem_to_reg, reg_write, alu_src_a;
  logic                pc_to_reg, ext_mode, illegal_op;
  logic [REGDST_W-1:0] reg_dst;
  logic [1:0]          alu_src_b, pc_source;
  logic [ALUOP_W-1:0]  alu_op;

  always_comb begin
    // Anything not listed, including unreachable encodings, returns to FETCH.
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_IMMEX;
`ifdef MULTICYCLE_CUSTOM_OPS_EN
          OP_JAL:            state_d = ST_JAL;
          OP_ANDI, OP_ORI:   state_d = ST_IMMEX;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (bus.op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = bus.mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_RWB;
      ST_IMMEX:  state_d = ST_IMMWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  multicycle_out_decode #(
    .ALUOP_W  (ALUOP_W),
    .REGDST_W (REGDST_W)
  ) u_decode (
    .state         (state_q),
    .op            (bus.op),
    .mem_ready     (bus.mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .pc_to_reg     (pc_to_reg),
    .ext_mode      (ext_mode),
    .illegal_op    (illegal_op)
  );

  // Reset gates the outputs combinationally so an in-flight memory write or
  // register write is withdrawn at once, not at the next clock edge.
  assign bus.PCWrite     = ~reset & pc_write;
  assign bus.PCWriteCond = ~reset & pc_write_cond;
  assign bus.IorD        = ~reset & i_or_d;
  assign bus.MemRead     = ~reset & mem_read;
  assign bus.MemWrite    = ~reset & mem_write;
  assign bus.IRWrite     = ~reset & ir_write;
  assign bus.MemtoReg    = ~reset & mem_to_reg;
  assign bus.RegDst      = reset ? '0 : reg_dst;
  assign bus.RegWrite    = ~reset & reg_write;
  assign bus.ALUSrcA     = ~reset & alu_src_a;
  assign bus.ALUSrcB     = reset ? '0 : alu_src_b;
  assign bus.ALUOp       = reset ? '0 : alu_op;
  assign bus.PCSource    = reset ? '0 : pc_source;
  assign bus.PCToReg     = ~reset & pc_to_reg;
  assign bus.ExtMode     = ~reset & ext_mode;
  assign bus.illegal_op  = ~reset & illegal_op;
  assign bus.state       = reset ? '0 : STATE_W'(state_q);

endmodule
